// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and timing defaults
// Purpose: scheduler state encoding and the game-second defaults shared
//          with the player controllers.
// Ports:   none (package).
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FREEZE   = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_COOLDOWN = 2'd3
  } bludge_state_t;

  localparam int DEF_CLK_PER_SEC      = 50_000_000;
  localparam int DEF_BLUDGE_SECONDS   = 10;
  localparam int DEF_COOLDOWN_SECONDS = 3;

endpackage

// File: rtl/bludge_scheduler_if.sv
// rtl/bludge_scheduler_if.sv - bludger request/freeze signal bundle
// Purpose: groups collision requests, pause and the freeze outputs.
// Ports:   master = collision/game side (drives hit_req, pause);
//          slave  = scheduler (drives bludged, bludge_time, clean_bludge,
//          grant_idx, busy).
interface bludge_scheduler_if #(
  parameter int NUM_PLAYERS = 4
);
  localparam int GW = $clog2(NUM_PLAYERS);

  logic [NUM_PLAYERS-1:0] hit_req;
  logic                   pause;
  logic [NUM_PLAYERS-1:0] bludged;
  logic [3:0]             bludge_time;
  logic                   clean_bludge;
  logic [GW-1:0]          grant_idx;
  logic                   busy;

  modport master (
    output hit_req, pause,
    input  bludged, bludge_time, clean_bludge, grant_idx, busy
  );

  modport slave (
    input  hit_req, pause,
    output bludged, bludge_time, clean_bludge, grant_idx, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority encoder
// Purpose: picks the first set request scanning upward from last+1,
//          wrapping modulo N.
// Ports:   i_req[N] requests, i_last previous winner,
//          o_gnt_valid any request set, o_gnt_idx winning index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic                 o_gnt_valid,
  output logic [$clog2(N)-1:0] o_gnt_idx
);
  localparam int IW = $clog2(N);

  // Offset k=N wraps back to i_last itself, so the previous winner has
  // the lowest priority but is still granted when it is the only request.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!o_gnt_valid && i_req[(int'(i_last) + k) % N]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = IW'((int'(i_last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/bludge_scheduler.sv
// rtl/bludge_scheduler.sv - bludger freeze arbitration and timing
// Purpose: grants the bludger round-robin, freezes the victim for
//          BLUDGE_SECONDS, pulses clean_bludge on release, then enforces
//          a cooldown before the next strike.
// Ports:   clk, rst (sync, active-high); bus (slave modport) carries
//          hit_req/pause in and bludged/bludge_time/clean_bludge/
//          grant_idx/busy out, all outputs registered.
module bludge_scheduler
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS      = 4,
  parameter int CLK_PER_SEC      = DEF_CLK_PER_SEC,
  parameter int BLUDGE_SECONDS   = DEF_BLUDGE_SECONDS,
  parameter int COOLDOWN_SECONDS = DEF_COOLDOWN_SECONDS
) (
  input  logic              clk,
  input  logic              rst,
  bludge_scheduler_if.slave bus
);
  localparam int GW    = $clog2(NUM_PLAYERS);
  localparam int SEC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_PER_SEC - 1);
  localparam logic [3:0]       BLUDGE_T = 4'(BLUDGE_SECONDS);
  localparam logic [3:0]       CD_LAST  = 4'(COOLDOWN_SECONDS - 1);
  localparam logic [GW-1:0]    LAST_RST = GW'(NUM_PLAYERS - 1);

  bludge_state_t          r_state;
  logic [NUM_PLAYERS-1:0] r_bludged;
  logic [3:0]             r_bludge_time;
  logic                   r_clean;
  logic [GW-1:0]          r_grant_idx;
  logic [GW-1:0]          r_last_grant;
  logic                   r_busy;
  logic [SEC_W-1:0]       r_sec_cnt;
  logic [3:0]             r_cd_secs;

  logic                   w_gnt_valid;
  logic [GW-1:0]          w_gnt_idx;
  logic                   w_sec_end;

  rr_arbiter #(.N(NUM_PLAYERS)) u_arb (
    .i_req       (bus.hit_req),
    .i_last      (r_last_grant),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_sec_end = (r_sec_cnt == SEC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bludged     <= '0;
      r_bludge_time <= '0;
      r_clean       <= 1'b0;
      r_grant_idx   <= '0;
      r_last_grant  <= LAST_RST;
      r_busy        <= 1'b0;
      r_sec_cnt     <= '0;
      r_cd_secs     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_bludged     <= NUM_PLAYERS'(1) << w_gnt_idx;
            r_grant_idx   <= w_gnt_idx;
            r_last_grant  <= w_gnt_idx;
            r_bludge_time <= BLUDGE_T;
            r_sec_cnt     <= '0;
            r_busy        <= 1'b1;
            r_state       <= ST_FREEZE;
          end
        end
        ST_FREEZE: begin
          // Pause has priority over the terminal count.
          if (!bus.pause) begin
            if (w_sec_end) begin
              r_sec_cnt     <= '0;
              r_bludge_time <= r_bludge_time - 4'd1;
              if (r_bludge_time == 4'd1) begin
                r_bludged <= '0;
                r_clean   <= 1'b1;
                r_state   <= ST_RELEASE;
              end
            end else begin
              r_sec_cnt <= r_sec_cnt + SEC_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          r_clean   <= 1'b0;
          r_sec_cnt <= '0;
          r_cd_secs <= '0;
          r_state   <= ST_COOLDOWN;
        end
        ST_COOLDOWN: begin
          // Whole seconds counted in r_cd_secs; avoids a cycle multiplier.
          if (!bus.pause) begin
            if (w_sec_end) begin
              r_sec_cnt <= '0;
              if (r_cd_secs == CD_LAST) begin
                r_cd_secs <= '0;
                r_busy    <= 1'b0;
                r_state   <= ST_IDLE;
              end else begin
                r_cd_secs <= r_cd_secs + 4'd1;
              end
            end else begin
              r_sec_cnt <= r_sec_cnt + SEC_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bludged      = r_bludged;
  assign bus.bludge_time  = r_bludge_time;
  assign bus.clean_bludge = r_clean;
  assign bus.grant_idx    = r_grant_idx;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_bludge_scheduler.sv
// tb/tb_bludge_scheduler.sv - scoreboard bench for bludge_scheduler
module tb_bludge_scheduler;
  localparam int N   = 4;
  localparam int CPS = 4;
  localparam int BS  = 3;
  localparam int CD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bludge_scheduler_if #(.NUM_PLAYERS(N)) bif ();

  bludge_scheduler #(
    .NUM_PLAYERS      (N),
    .CLK_PER_SEC      (CPS),
    .BLUDGE_SECONDS   (BS),
    .COOLDOWN_SECONDS (CD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic [N-1:0] bludged;
    logic [3:0]   btime;
    logic         clean;
    logic [1:0]   gidx;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: phases with a count of remaining unpaused cycles;
  // seconds shown are the ceiling of remaining cycles over CPS.
  initial begin : model
    int     phase;
    int     rem;
    int     last;
    int     victim;
    logic [N-1:0] h;
    logic   p;
    exp_t   e;
    phase = 0; rem = 0; last = N - 1; victim = 0;
    forever begin
      @(posedge clk);
      h = bif.hit_req;
      p = bif.pause;
      if (rst) begin
        phase = 0; last = N - 1; victim = 0; rem = 0;
      end else begin
        case (phase)
          0: if (h != 0) begin
               for (int k = 1; k <= N; k++) begin
                 if (h[(last + k) % N]) begin
                   victim = (last + k) % N;
                   break;
                 end
               end
               last  = victim;
               phase = 1;
               rem   = BS * CPS;
             end
          1: if (!p) begin
               rem = rem - 1;
               if (rem == 0) phase = 2;
             end
          2: begin
               phase = 3;
               rem   = CD * CPS;
             end
          default: if (!p) begin
               rem = rem - 1;
               if (rem == 0) phase = 0;
             end
        endcase
      end
      e.bludged = (phase == 1) ? N'(1 << victim) : '0;
      e.btime   = (phase == 1) ? 4'((rem + CPS - 1) / CPS) : 4'd0;
      e.clean   = (phase == 2);
      e.gidx    = 2'(victim);
      e.busy    = (phase != 0);
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got 0 entries expected >=1 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("bludged",      32'(bif.bludged),      32'(e.bludged));
          chk("bludge_time",  32'(bif.bludge_time),  32'(e.btime));
          chk("clean_bludge", 32'(bif.clean_bludge), 32'(e.clean));
          chk("grant_idx",    32'(bif.grant_idx),    32'(e.gidx));
          chk("busy",         32'(bif.busy),         32'(e.busy));
          chk("onehot",       32'($countones(bif.bludged) <= 1), 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    bif.hit_req = '0;
    bif.pause   = 1'b0;
    rst         = 1'b1;
    tick(3);
    rst = 1'b0;

    // basic freeze
    bif.hit_req = 4'b0010; tick(1);
    bif.hit_req = '0;      tick(25);

    // round-robin with all requests held
    bif.hit_req = 4'b1111; tick(5 * 22 + 2);
    bif.hit_req = '0;      tick(25);

    // requests ignored during freeze and cooldown
    bif.hit_req = 4'b0100; tick(1);
    bif.hit_req = '0;      tick(2);
    bif.hit_req = 4'b0001; tick(18);
    bif.hit_req = '0;      tick(10);

    // pause mid-freeze
    bif.hit_req = 4'b1000; tick(1);
    bif.hit_req = '0;      tick(4);
    bif.pause   = 1'b1;    tick(10);
    bif.pause   = 1'b0;    tick(25);

    // reset mid-freeze, then priority restarts at player 0
    bif.hit_req = 4'b1000; tick(1);
    bif.hit_req = '0;      tick(5);
    rst = 1'b1;            tick(1);
    rst = 1'b0;
    bif.hit_req = 4'b1111; tick(1);
    bif.hit_req = '0;      tick(25);

    // pause exactly on the terminal count of the first second
    bif.hit_req = 4'b0100; tick(1);
    bif.hit_req = '0;      tick(3);
    bif.pause   = 1'b1;    tick(1);
    bif.pause   = 1'b0;    tick(25);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bif.hit_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bif.pause   = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    bif.hit_req = '0;
    bif.pause   = 1'b0;
    tick(5);

    @(posedge clk);
    done = 1'b1;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
